pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
Frame-synchronous game sequencer for the Pong VGA datapath. Once per video frame, during vertical blanking, it updates ball and paddle positions, resolves wall, paddle and goal collisions, and keeps score. It drives the coordinate, score and screen-select (`o_sel`) inputs of the VGA renderer, so the screen stays static while pixels are being drawn.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines
PADDLE_H, 64, paddle height in pixels (paddle width fixed at 8)
BALL_SIZE, 8, ball edge length in pixels
PADDLE_STEP, 4, paddle movement per frame
BALL_SPEED, 2, ball movement per frame on each axis
WIN_SCORE, 9, points needed to win
SERVE_FRAMES, 60, frames the ball is held before launch

Ports:
CLOCK_50  in  1  system clock
i_rst_n  in  1  synchronous reset, active-low
i_frame_tick  in  1  one-cycle pulse at start of vertical blanking, from the VGA timing block
i_start  in  1  start/restart request, level
i_p1_up, i_p1_dn  in  1 each  left paddle controls
i_p2_up, i_p2_dn  in  1 each  right paddle controls
o_ball_x, o_ball_y  out  10 each  ball top-left corner
o_p1_y, o_p2_y  out  10 each  paddle top edge
o_score1, o_score2  out  4 each  scores
o_state  out  3  FSM state encoding
o_sel  out  2  VGA screen select: 00 game, 01 attract, 10 game over

Behaviour:
- Reset (`i_rst_n` = 0 at a clock edge) overrides all other inputs in that cycle, including `i_frame_tick`.
- Reset values:
  - ball = (316, 236)
  - paddles = 208
  - scores = 0
  - state = IDLE, `o_sel` = 01
  - internal dx = +, dy = +, serve counter = 0
- All outputs are registered. Positions and scores change only on the clock edge that samples `i_frame_tick` = 1, i.e. latency 1 cycle from the tick.
- FSM states: IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4.
- IDLE:
  - `i_start` = 1 → SERVE; load serve counter = SERVE_FRAMES; recentre the ball.
  - No tick is needed for this transition. If a tick arrives in the same cycle, only the transition happens.
- SERVE:
  - Paddles move; the ball is held at centre.
  - The serve counter decrements on each tick. The tick on which it reaches 0 → PLAY.
- PLAY, on each tick:
  - Paddles move.
  - Compute next_x = x ± BALL_SPEED and next_y = y ± BALL_SPEED.
- Wall collisions:
  - next_y ≤ 0 → y = 0, dy = +.
  - next_y ≥ V_ACTIVE − BALL_SIZE (472) → y = 472, dy = −.
- Paddle overlap is defined as: ball_y + BALL_SIZE > paddle_y AND ball_y < paddle_y + PADDLE_H.
- Left side, dx = −:
  - next_x ≤ 24 with p1 overlap → x = 24, dx = +.
  - Otherwise, x < BALL_SPEED → P2 scores; go to POINT.
- Right side, dx = +:
  - next_x + 8 ≥ 616 with p2 overlap → x = 608, dx = −.
  - Otherwise, next_x > 632 → P1 scores; go to POINT.
- Wall and paddle collisions in the same frame are both applied.
- POINT, for one tick:
  - Score increments saturate at WIN_SCORE.
  - If a score equals WIN_SCORE → OVER. Otherwise → SERVE with the ball recentred and dx pointing toward the player who conceded; dy = +.
- OVER:
  - `o_sel` = 10; positions are frozen.
  - `i_start` → clear scores; go to SERVE with dx = +.
- `o_sel` is 00 in SERVE, PLAY and POINT, and 01 in IDLE.
- Paddle movement, applied per tick:
  - up alone → y − PADDLE_STEP, clamped at 0.
  - down alone → y + PADDLE_STEP, clamped at V_ACTIVE − PADDLE_H (416).
  - Both pressed or neither → no move.
  - Paddles do not move in IDLE or OVER.

Optional Feature:
- Macro: `PONG_AI_EN`.
- Defined: the right paddle ignores `i_p2_up`/`i_p2_dn`. Each tick, it moves toward the ball by PADDLE_STEP when its centre (p2_y + 32) differs from the ball centre (ball_y + 4) by more than PADDLE_STEP, with the same clamping.
- Undefined: the right paddle is driven by the player inputs only.

Decomposition:
- Shared package `pong_pkg`:
  - FSM state encoding.
  - `o_sel` codes.
  - Screen and paddle geometry constants: paddle faces 24 and 616, centre coordinates 316/236/208.
- Sub-module `pong_paddle_mover`: clamped up/down stepping per tick, with a registered y output. Instantiated twice.

Test Plan:
- Reset mid-PLAY with a tick in the same cycle → next cycle: ball (316, 236), paddles 208, scores 0, state 0, `o_sel` 01.
- `i_start` in IDLE, then 60 ticks → state SERVE for exactly 60 ticks, then PLAY; on the first PLAY tick o_ball_x = 318.
- p1 holds up from 208 for 60 ticks → o_p1_y = 0 and stays at 0. Both buttons pressed → o_p1_y unchanged.
- Ball moving right toward p2 = 208 at y = 240 → bounces at x = 608 and dx flips. Repeat with p2 = 0 → score1 increments, POINT for 1 tick, then SERVE with the ball moving left.
- Ball at y = 2 moving up → y = 0, then y = 2 on the next tick.
- score1 = 8 and P1 scores → score1 = 9, state OVER, `o_sel` 10. `i_start` → scores 0, state SERVE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game sequencer: state and screen-select
// encodings, screen/paddle geometry and small scoring helpers.
package pong_pkg;

  typedef logic [9:0] coord_t;
  typedef logic [3:0] score_t;
  typedef logic [5:0] serve_cnt_t;

  localparam coord_t     H_ACTIVE     = 10'd640;
  localparam coord_t     V_ACTIVE     = 10'd480;
  localparam coord_t     PADDLE_H     = 10'd64;
  localparam coord_t     BALL_SIZE    = 10'd8;
  localparam coord_t     PADDLE_STEP  = 10'd4;
  localparam coord_t     BALL_SPEED   = 10'd2;
  localparam score_t     WIN_SCORE    = 4'd9;
  localparam serve_cnt_t SERVE_FRAMES = 6'd60;

  // Paddle faces: right edge of the left paddle, left edge of the right paddle.
  localparam coord_t FACE_L       = 10'd24;
  localparam coord_t FACE_R       = H_ACTIVE - FACE_L;
  localparam coord_t BALL_X0      = (H_ACTIVE - BALL_SIZE) >> 1;
  localparam coord_t BALL_Y0      = (V_ACTIVE - BALL_SIZE) >> 1;
  localparam coord_t PADDLE_Y0    = (V_ACTIVE - PADDLE_H) >> 1;
  localparam coord_t BALL_X_MAX   = H_ACTIVE - BALL_SIZE;
  localparam coord_t BALL_Y_MAX   = V_ACTIVE - BALL_SIZE;
  localparam coord_t PADDLE_Y_MAX = V_ACTIVE - PADDLE_H;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SEL_GAME    = 2'b00,
    SEL_ATTRACT = 2'b01,
    SEL_OVER    = 2'b10
  } sel_e;

  function automatic sel_e sel_of(input state_e s);
    case (s)
      ST_IDLE: return SEL_ATTRACT;
      ST_OVER: return SEL_OVER;
      default: return SEL_GAME;
    endcase
  endfunction

  function automatic score_t sat_inc(input score_t s);
    return (s >= WIN_SCORE) ? WIN_SCORE : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_paddle_mover.sv
// One paddle: clamped up/down stepping, applied only when step is asserted.
module pong_paddle_mover
  import pong_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   step,
  input  logic   up,
  input  logic   dn,
  output coord_t y
);

  // Pressing both buttons cancels out, as does pressing neither.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y <= PADDLE_Y0;
    end else if (step && (up ^ dn)) begin
      if (up) y <= (y < PADDLE_STEP) ? '0 : y - PADDLE_STEP;
      else    y <= (y > PADDLE_Y_MAX - PADDLE_STEP) ? PADDLE_Y_MAX : y + PADDLE_STEP;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-synchronous Pong sequencer: ball, paddles, collisions and score.
// Define PONG_AI_EN to let the right paddle track the ball on its own.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_start,
  input  logic       i_p1_up,
  input  logic       i_p1_dn,
  input  logic       i_p2_up,
  input  logic       i_p2_dn,
  output logic [9:0] o_ball_x,
  output logic [9:0] o_ball_y,
  output logic [9:0] o_p1_y,
  output logic [9:0] o_p2_y,
  output logic [3:0] o_score1,
  output logic [3:0] o_score2,
  output logic [2:0] o_state,
  output logic [1:0] o_sel
);

  state_e     state, state_n;
  sel_e       sel;
  coord_t     ball_x, ball_x_n, ball_y, ball_y_n;
  coord_t     p1_y, p2_y;
  score_t     score1, score1_n, score2, score2_n;
  serve_cnt_t serve_cnt, serve_cnt_n;
  logic       dx_pos, dx_pos_n, dy_pos, dy_pos_n;
  logic       p1_scored, p1_scored_n;
  logic       paddle_step, p1_ov, p2_ov, p2_up, p2_dn;

  assign paddle_step = i_frame_tick && (state == ST_SERVE || state == ST_PLAY ||
                                        state == ST_POINT);

  // Overlap uses the positions drawn in the frame that just ended.
  assign p1_ov = (ball_y + BALL_SIZE > p1_y) && (ball_y < p1_y + PADDLE_H);
  assign p2_ov = (ball_y + BALL_SIZE > p2_y) && (ball_y < p2_y + PADDLE_H);

`ifdef PONG_AI_EN
  logic [9:0] p2_mid, ball_mid;
  assign p2_mid   = p2_y + (PADDLE_H >> 1);
  assign ball_mid = ball_y + (BALL_SIZE >> 1);
  assign p2_up    = p2_mid > ball_mid + PADDLE_STEP;
  assign p2_dn    = ball_mid > p2_mid + PADDLE_STEP;
`else
  assign p2_up = i_p2_up;
  assign p2_dn = i_p2_dn;
`endif

  pong_paddle_mover u_p1 (
    .clk   (CLOCK_50),
    .rst_n (i_rst_n),
    .step  (paddle_step),
    .up    (i_p1_up),
    .dn    (i_p1_dn),
    .y     (p1_y)
  );

  pong_paddle_mover u_p2 (
    .clk   (CLOCK_50),
    .rst_n (i_rst_n),
    .step  (paddle_step),
    .up    (p2_up),
    .dn    (p2_dn),
    .y     (p2_y)
  );

  // NOTE: every variable gets a default first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    ball_x_n    = ball_x;
    ball_y_n    = ball_y;
    dx_pos_n    = dx_pos;
    dy_pos_n    = dy_pos;
    score1_n    = score1;
    score2_n    = score2;
    serve_cnt_n = serve_cnt;
    p1_scored_n = p1_scored;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_n     = ST_SERVE;
          serve_cnt_n = SERVE_FRAMES;
          ball_x_n    = BALL_X0;
          ball_y_n    = BALL_Y0;
        end
      end

      ST_SERVE: begin
        if (i_frame_tick) begin
          serve_cnt_n = serve_cnt - 6'd1;
          if (serve_cnt <= 6'd1) begin
            serve_cnt_n = '0;
            state_n     = ST_PLAY;
          end
        end
      end

      ST_PLAY: begin
        if (i_frame_tick) begin
          if (!dy_pos) begin
            if (ball_y <= BALL_SPEED) begin
              ball_y_n = '0;
              dy_pos_n = 1'b1;
            end else begin
              ball_y_n = ball_y - BALL_SPEED;
            end
          end else begin
            if (ball_y + BALL_SPEED >= BALL_Y_MAX) begin
              ball_y_n = BALL_Y_MAX;
              dy_pos_n = 1'b0;
            end else begin
              ball_y_n = ball_y + BALL_SPEED;
            end
          end

          // Thresholds are stated on the current x so next_x never underflows.
          if (!dx_pos) begin
            if (ball_x <= FACE_L + BALL_SPEED && p1_ov) begin
              ball_x_n = FACE_L;
              dx_pos_n = 1'b1;
            end else if (ball_x < BALL_SPEED) begin
              state_n     = ST_POINT;
              p1_scored_n = 1'b0;
            end else begin
              ball_x_n = ball_x - BALL_SPEED;
            end
          end else begin
            if (ball_x + BALL_SPEED + BALL_SIZE >= FACE_R && p2_ov) begin
              ball_x_n = FACE_R - BALL_SIZE;
              dx_pos_n = 1'b0;
            end else if (ball_x + BALL_SPEED > BALL_X_MAX) begin
              state_n     = ST_POINT;
              p1_scored_n = 1'b1;
            end else begin
              ball_x_n = ball_x + BALL_SPEED;
            end
          end
        end
      end

      ST_POINT: begin
        if (i_frame_tick) begin
          if (p1_scored) score1_n = sat_inc(score1);
          else           score2_n = sat_inc(score2);
          if (score1_n == WIN_SCORE || score2_n == WIN_SCORE) begin
            state_n = ST_OVER;
          end else begin
            state_n     = ST_SERVE;
            serve_cnt_n = SERVE_FRAMES;
            ball_x_n    = BALL_X0;
            ball_y_n    = BALL_Y0;
            dx_pos_n    = p1_scored;
            dy_pos_n    = 1'b1;
          end
        end
      end

      ST_OVER: begin
        if (i_start) begin
          state_n     = ST_SERVE;
          serve_cnt_n = SERVE_FRAMES;
          score1_n    = '0;
          score2_n    = '0;
          ball_x_n    = BALL_X0;
          ball_y_n    = BALL_Y0;
          dx_pos_n    = 1'b1;
          dy_pos_n    = 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      sel       <= SEL_ATTRACT;
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      dx_pos    <= 1'b1;
      dy_pos    <= 1'b1;
      score1    <= '0;
      score2    <= '0;
      serve_cnt <= '0;
      p1_scored <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_of(state_n);
      ball_x    <= ball_x_n;
      ball_y    <= ball_y_n;
      dx_pos    <= dx_pos_n;
      dy_pos    <= dy_pos_n;
      score1    <= score1_n;
      score2    <= score2_n;
      serve_cnt <= serve_cnt_n;
      p1_scored <= p1_scored_n;
    end
  end

  assign o_ball_x = ball_x;
  assign o_ball_y = ball_y;
  assign o_p1_y   = p1_y;
  assign o_p2_y   = p2_y;
  assign o_score1 = score1;
  assign o_score2 = score2;
  assign o_state  = state;
  assign o_sel    = sel;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: directed frames, hand-computed
// expectations queued per update event and checked by a separate monitor.
module tb_pong_game_ctrl;

  typedef enum int {F_BX, F_BY, F_P1, F_P2, F_S1, F_S2, F_ST, F_SEL} fld_e;
  typedef struct {
    int    evt;
    fld_e  fld;
    int    val;
    string name;
  } exp_t;

  logic       clk;
  logic       i_rst_n, i_frame_tick, i_start;
  logic       i_p1_up, i_p1_dn, i_p2_up, i_p2_dn;
  logic [9:0] o_ball_x, o_ball_y, o_p1_y, o_p2_y;
  logic [3:0] o_score1, o_score2;
  logic [2:0] o_state;
  logic [1:0] o_sel;

  exp_t q[$];
  int   evt_no  = 0;
  int   mon_evt = 0;
  int   checks  = 0;
  int   errors  = 0;

  pong_game_ctrl dut (
    .CLOCK_50     (clk),
    .i_rst_n      (i_rst_n),
    .i_frame_tick (i_frame_tick),
    .i_start      (i_start),
    .i_p1_up      (i_p1_up),
    .i_p1_dn      (i_p1_dn),
    .i_p2_up      (i_p2_up),
    .i_p2_dn      (i_p2_dn),
    .o_ball_x     (o_ball_x),
    .o_ball_y     (o_ball_y),
    .o_p1_y       (o_p1_y),
    .o_p2_y       (o_p2_y),
    .o_score1     (o_score1),
    .o_score2     (o_score2),
    .o_state      (o_state),
    .o_sel        (o_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expectation for the next update event (tick, start or reset edge).
  task automatic push_exp(input fld_e f, input int v, input string n);
    exp_t e;
    e.evt  = evt_no + 1;
    e.fld  = f;
    e.val  = v;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic push_all(input int bx, input int by, input int p1, input int p2,
                          input int s1, input int s2, input int st, input int sel,
                          input string n);
    push_exp(F_BX,  bx,  {n, "_ball_x"});
    push_exp(F_BY,  by,  {n, "_ball_y"});
    push_exp(F_P1,  p1,  {n, "_p1_y"});
    push_exp(F_P2,  p2,  {n, "_p2_y"});
    push_exp(F_S1,  s1,  {n, "_score1"});
    push_exp(F_S2,  s2,  {n, "_score2"});
    push_exp(F_ST,  st,  {n, "_state"});
    push_exp(F_SEL, sel, {n, "_sel"});
  endtask

  // One update cycle followed by one idle cycle.
  task automatic pulse(input logic tk, input logic st, input logic rs);
    i_frame_tick = tk;
    i_start      = st;
    i_rst_n      = rs;
    @(posedge clk);
    #1;
    i_frame_tick = 1'b0;
    i_start      = 1'b0;
    i_rst_n      = 1'b1;
    if (tk || st || !rs) evt_no++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: counts update edges and checks every expectation tagged for it.
  initial begin
    logic hit;
    exp_t e;
    logic [31:0] act;
    forever begin
      @(posedge clk);
      hit = i_frame_tick || i_start || !i_rst_n;
      @(negedge clk);
      if (hit) begin
        mon_evt++;
        while (q.size() > 0 && q[0].evt <= mon_evt) begin
          e = q.pop_front();
          case (e.fld)
            F_BX:    act = 32'(o_ball_x);
            F_BY:    act = 32'(o_ball_y);
            F_P1:    act = 32'(o_p1_y);
            F_P2:    act = 32'(o_p2_y);
            F_S1:    act = 32'(o_score1);
            F_S2:    act = 32'(o_score2);
            F_ST:    act = 32'(o_state);
            default: act = 32'(o_sel);
          endcase
          check(e.name, act, 32'(e.val));
        end
      end
    end
  end

  initial begin
    i_rst_n = 1'b0; i_frame_tick = 1'b0; i_start = 1'b0;
    i_p1_up = 1'b0; i_p1_dn = 1'b0; i_p2_up = 1'b0; i_p2_dn = 1'b0;

    pulse(1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0);
    push_all(316, 236, 208, 208, 0, 0, 0, 1, "reset");
    pulse(1'b0, 1'b0, 1'b0);

    push_exp(F_ST, 0, "idle_tick_state");
    push_exp(F_BX, 316, "idle_tick_ball_x");
    pulse(1'b1, 1'b0, 1'b1);

    // Start with a coincident tick: only the transition, paddles stay put.
    i_p1_up = 1'b1;
    i_p2_dn = 1'b1;
    push_exp(F_ST, 1, "start_state");
    push_exp(F_SEL, 0, "start_sel");
    push_exp(F_P1, 208, "start_p1_frozen");
    push_exp(F_P2, 208, "start_p2_frozen");
    pulse(1'b1, 1'b1, 1'b1);

    for (int t = 1; t <= 60; t++) begin
      i_p1_dn = (t == 1);
      if (t == 1)  begin push_exp(F_P1, 208, "both_pressed_p1"); push_exp(F_P2, 212, "p2_down_1"); end
      if (t == 2)  push_exp(F_P1, 204, "p1_up_1");
      if (t == 52) push_exp(F_P2, 416, "p2_clamp_bottom");
      if (t == 53) push_exp(F_P1, 0, "p1_clamp_top");
      if (t == 59) push_exp(F_ST, 1, "serve_tick59_state");
      if (t == 60) begin
        push_exp(F_ST, 2, "serve_end_state");
        push_exp(F_P1, 0, "p1_stays_top");
        push_exp(F_P2, 416, "p2_stays_bottom");
        push_exp(F_BX, 316, "serve_ball_held_x");
        push_exp(F_BY, 236, "serve_ball_held_y");
      end
      pulse(1'b1, 1'b0, 1'b1);
    end
    i_p1_up = 1'b0;
    i_p1_dn = 1'b0;
    i_p2_dn = 1'b0;

    // Long first rally: bottom wall, p2 bounce, top wall, p1 bounce, P1 point.
    for (int n = 1; n <= 744; n++) begin
      i_p1_dn = (n >= 356 && n <= 390);
      i_p2_up = (n >= 440 && n <= 543);
      case (n)
        1:   begin push_exp(F_BX, 318, "play1_x"); push_exp(F_BY, 238, "play1_y"); end
        118: begin push_exp(F_BX, 552, "wall_bot_x"); push_exp(F_BY, 472, "wall_bot_y"); end
        119: push_exp(F_BY, 470, "wall_bot_rebound_y");
        146: begin push_exp(F_BX, 608, "p2_bounce_x"); push_exp(F_BY, 416, "p2_bounce_y"); end
        147: push_exp(F_BX, 606, "p2_bounce_dx_flip");
        353: begin push_exp(F_BX, 194, "wall_top_pre_x"); push_exp(F_BY, 2, "wall_top_pre_y"); end
        354: push_exp(F_BY, 0, "wall_top_y");
        355: push_exp(F_BY, 2, "wall_top_rebound_y");
        390: push_exp(F_P1, 140, "p1_moved_down");
        438: begin push_exp(F_BX, 24, "p1_bounce_x"); push_exp(F_BY, 168, "p1_bounce_y"); end
        439: push_exp(F_BX, 26, "p1_bounce_dx_flip");
        543: push_exp(F_P2, 0, "p2_moved_top");
        743: begin
          push_exp(F_ST, 3, "p1_miss_point_state");
          push_exp(F_BX, 632, "p1_miss_ball_x");
          push_exp(F_BY, 166, "p1_miss_ball_y");
          push_exp(F_S1, 0, "p1_miss_score_pending");
        end
        744: begin
          push_exp(F_S1, 1, "point1_score1");
          push_exp(F_S2, 0, "point1_score2");
          push_exp(F_ST, 1, "point1_to_serve");
          push_exp(F_SEL, 0, "point1_sel");
          push_exp(F_BX, 316, "point1_recentre_x");
          push_exp(F_BY, 236, "point1_recentre_y");
        end
        default: ;
      endcase
      pulse(1'b1, 1'b0, 1'b1);
    end
    i_p1_dn = 1'b0;
    i_p2_up = 1'b0;

    // Points 2..9 for P1: p2 parked at 0, ball served to the right each time.
    for (int p = 2; p <= 9; p++) begin
      for (int t = 1; t <= 60; t++) begin
        if (t == 60) push_exp(F_ST, 2, "round_serve_done");
        pulse(1'b1, 1'b0, 1'b1);
      end
      for (int n = 1; n <= 159; n++) begin
        if (n == 1) push_exp(F_BX, 318, "round_serve_dx_right");
        if (n == 159) begin
          push_exp(F_ST, 3, "round_point_state");
          push_exp(F_BX, 632, "round_exit_x");
          push_exp(F_BY, 390, "round_exit_y");
        end
        pulse(1'b1, 1'b0, 1'b1);
      end
      push_exp(F_S1, p, "round_score1");
      push_exp(F_ST, (p == 9) ? 4 : 1, "round_next_state");
      push_exp(F_SEL, (p == 9) ? 2 : 0, "round_sel");
      pulse(1'b1, 1'b0, 1'b1);
    end

    // OVER: everything frozen, even with a paddle button held.
    i_p1_dn = 1'b1;
    push_exp(F_P1, 140, "over_p1_frozen");
    push_exp(F_BX, 632, "over_ball_x_frozen");
    push_exp(F_BY, 390, "over_ball_y_frozen");
    push_exp(F_ST, 4, "over_state");
    push_exp(F_S1, 9, "over_score1_saturated");
    pulse(1'b1, 1'b0, 1'b1);
    i_p1_dn = 1'b0;

    push_all(316, 236, 140, 0, 0, 0, 1, 0, "restart");
    pulse(1'b0, 1'b1, 1'b1);

    for (int t = 1; t <= 60; t++) begin
      if (t == 60) push_exp(F_ST, 2, "restart_serve_done");
      pulse(1'b1, 1'b0, 1'b1);
    end
    for (int n = 1; n <= 5; n++) begin
      if (n == 1) begin
        push_exp(F_BX, 318, "restart_dx_right");
        push_exp(F_BY, 238, "restart_dy_down");
      end
      pulse(1'b1, 1'b0, 1'b1);
    end

    // Reset mid-PLAY with a coincident tick.
    push_all(316, 236, 208, 208, 0, 0, 0, 1, "reset_mid_play");
    pulse(1'b1, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
